// File: rtl/writer.sv
// Block writer: buffers {address, block} requests in a small FIFO and streams
// each block out as consecutive 16-bit Avalon-MM writes, most significant halfword first.
module writer #(
  parameter int unsigned NDWORDS   = 1,
  parameter int unsigned FIFODEPTH = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [31:0]             baseaddr,
  input  logic [31:0]             index,
  input  logic                    write,
  input  logic [32*NDWORDS-1:0]   data,
  output logic                    oready,
  output logic                    busy,
  output logic                    avm_m0_write,
  output logic [31:0]             avm_m0_address,
  output logic [15:0]             avm_m0_writedata,
  output logic [1:0]              avm_m0_byteenable,
  input  logic                    avm_m0_waitrequest
);

  localparam int unsigned BLOCKSZ   = 32 * NDWORDS;
  localparam int unsigned NHALF     = 2 * NDWORDS;
  localparam int unsigned BLK_BYTES = 4 * NDWORDS;
  localparam int unsigned KW        = $clog2(NHALF);
  localparam int unsigned PW        = $clog2(FIFODEPTH);
  localparam int unsigned CW        = PW + 1;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] XFER = 1'b1;

  logic [0:0]         state_q, state_d;
  logic [KW-1:0]      k_q, k_d;
  logic               write_q, write_d;
  logic [31:0]        addr_q, addr_d;
  logic [15:0]        wdata_q, wdata_d;
  logic               oready_q, oready_d;
  logic               busy_q, busy_d;
  logic [CW-1:0]      count_q, count_d;
  logic [PW-1:0]      rd_q, rd_d;
  logic [PW-1:0]      wr_q, wr_d;

  logic [31:0]        mem_addr_q [FIFODEPTH];
  logic [BLOCKSZ-1:0] mem_data_q [FIFODEPTH];

  logic               push_c;
  logic               pop_c;
  logic               launch_c;
  logic [31:0]        blk_addr_c;
  logic [CW-1:0]      stored_c;
  logic [31:0]        head_addr_c;
  logic [BLOCKSZ-1:0] head_data_c;

  // Halfword k of a block, counted from the most significant end.
  function automatic logic [15:0] hword(input logic [BLOCKSZ-1:0] d, input logic [KW-1:0] k);
    hword = 16'(d >> (32'(BLOCKSZ - 16) - 32'(k) * 32'd16));
  endfunction

  always_comb begin
    push_c      = write & oready_q;
    blk_addr_c  = baseaddr + index * 32'(BLK_BYTES);
    pop_c       = (state_q == XFER) && !avm_m0_waitrequest && (k_q == KW'(NHALF - 1));
    count_d     = count_q + CW'(push_c) - CW'(pop_c);
    stored_c    = count_q - CW'(pop_c);
    wr_d        = wr_q + PW'(push_c);
    rd_d        = rd_q + PW'(pop_c);
    // Next block comes from the FIFO, or straight from the request being pushed now.
    head_addr_c = blk_addr_c;
    head_data_c = data;
    if (stored_c != '0) begin
      head_addr_c = mem_addr_q[rd_d];
      head_data_c = mem_data_q[rd_d];
    end
    launch_c    = ((state_q == IDLE) || pop_c) && (count_d != '0);

    state_d = state_q;
    k_d     = k_q;
    write_d = write_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    if (launch_c) begin
      state_d = XFER;
      k_d     = '0;
      write_d = 1'b1;
      addr_d  = head_addr_c;
      wdata_d = hword(head_data_c, KW'(0));
    end else if (pop_c) begin
      state_d = IDLE;
      k_d     = '0;
      write_d = 1'b0;
    end else if ((state_q == XFER) && !avm_m0_waitrequest) begin
      k_d     = k_q + KW'(1);
      addr_d  = addr_q + 32'd2;
      wdata_d = hword(mem_data_q[rd_q], k_d);
    end

    oready_d = (count_d != CW'(FIFODEPTH));
    busy_d   = (count_d != '0) || (state_d == XFER);
  end

  // Control and output registers; synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      k_q      <= '0;
      write_q  <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      oready_q <= 1'b1;
      busy_q   <= 1'b0;
      count_q  <= '0;
      rd_q     <= '0;
      wr_q     <= '0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      write_q  <= write_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      oready_q <= oready_d;
      busy_q   <= busy_d;
      count_q  <= count_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
    end
  end

  // Request storage; validity is tracked by the pointers alone.
  always_ff @(posedge clk) begin
    if (reset && push_c) begin
      mem_addr_q[wr_q] <= blk_addr_c;
      mem_data_q[wr_q] <= data;
    end
  end

  assign oready            = oready_q;
  assign busy              = busy_q;
  assign avm_m0_write      = write_q;
  assign avm_m0_address    = addr_q;
  assign avm_m0_writedata  = wdata_q;
  assign avm_m0_byteenable = 2'b11;

endmodule

// File: tb/tb_writer.sv
// Testbench for writer: directed scenarios plus random traffic, all checked
// cycle by cycle against a queue-based model of pending blocks.
module tb_writer;

  localparam int unsigned ND      = 1;
  localparam int unsigned DEPTH   = 4;
  localparam int unsigned BLOCKSZ = 32 * ND;
  localparam int unsigned NHALF   = 2 * ND;

  logic               clk = 1'b0;
  logic               reset;
  logic [31:0]        baseaddr;
  logic [31:0]        index;
  logic               write;
  logic [BLOCKSZ-1:0] data;
  logic               oready;
  logic               busy;
  logic               avm_m0_write;
  logic [31:0]        avm_m0_address;
  logic [15:0]        avm_m0_writedata;
  logic [1:0]         avm_m0_byteenable;
  logic               avm_m0_waitrequest;

  writer #(.NDWORDS(ND), .FIFODEPTH(DEPTH)) dut (
    .clk               (clk),
    .reset             (reset),
    .baseaddr          (baseaddr),
    .index             (index),
    .write             (write),
    .data              (data),
    .oready            (oready),
    .busy              (busy),
    .avm_m0_write      (avm_m0_write),
    .avm_m0_address    (avm_m0_address),
    .avm_m0_writedata  (avm_m0_writedata),
    .avm_m0_byteenable (avm_m0_byteenable),
    .avm_m0_waitrequest(avm_m0_waitrequest)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]        addr;
    logic [BLOCKSZ-1:0] data;
  } blk_t;

  blk_t q[$];
  int   prog = 0;
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Entered at a negedge: compare outputs to model, drive inputs, advance model one edge.
  task automatic step(input logic rst, input logic wr, input logic wt,
                      input logic [31:0] b, input logic [31:0] i, input logic [BLOCKSZ-1:0] d);
    logic [BLOCKSZ-1:0] sh;
    logic               push_ok;
    blk_t               nb;
    check("oready", 64'(oready), 64'(q.size() < DEPTH));
    check("busy", 64'(busy), 64'(q.size() != 0));
    check("write", 64'(avm_m0_write), 64'(q.size() != 0));
    check("byteen", 64'(avm_m0_byteenable), 64'h3);
    if (q.size() != 0) begin
      sh = q[0].data >> (BLOCKSZ - 16 - 16 * prog);
      check("addr", 64'(avm_m0_address), 64'(q[0].addr + 32'(2 * prog)));
      check("wdata", 64'(avm_m0_writedata), 64'(sh[15:0]));
    end
    reset = rst; write = wr; avm_m0_waitrequest = wt;
    baseaddr = b; index = i; data = d;
    @(posedge clk);
    if (!rst) begin
      q.delete();
      prog = 0;
    end else begin
      push_ok = wr && (q.size() < DEPTH);
      if (q.size() != 0 && !wt) begin
        prog++;
        if (prog == NHALF) begin
          void'(q.pop_front());
          prog = 0;
        end
      end
      if (push_ok) begin
        nb.addr = b + i * 32'(4 * ND);
        nb.data = d;
        q.push_back(nb);
      end
    end
    @(negedge clk);
  endtask

  task automatic idle(input logic wt);
    step(1'b1, 1'b0, wt, 32'h0, 32'h0, '0);
  endtask

  initial begin
    reset = 1'b0; write = 1'b0; avm_m0_waitrequest = 1'b0;
    baseaddr = '0; index = '0; data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_oready", 64'(oready), 64'h1);
    check("rst_busy", 64'(busy), 64'h0);
    check("rst_write", 64'(avm_m0_write), 64'h0);
    check("rst_addr", 64'(avm_m0_address), 64'h0);
    check("rst_wdata", 64'(avm_m0_writedata), 64'h0);

    // Single block, no stall
    step(1'b1, 1'b1, 1'b0, 32'h1000, 32'd2, 32'h0A0B0C0D);
    check("d33_a0", 64'(avm_m0_address), 64'h1008);
    check("d33_d0", 64'(avm_m0_writedata), 64'h0A0B);
    idle(1'b0);
    check("d33_a1", 64'(avm_m0_address), 64'h100A);
    check("d33_d1", 64'(avm_m0_writedata), 64'h0C0D);
    idle(1'b0);
    check("d33_busy", 64'(busy), 64'h0);
    check("d33_write", 64'(avm_m0_write), 64'h0);

    // Stall on first halfword
    step(1'b1, 1'b1, 1'b0, 32'h1000, 32'd2, 32'h0A0B0C0D);
    for (int c = 0; c < 3; c++) begin
      idle(1'b1);
      check("d34_hold_a", 64'(avm_m0_address), 64'h1008);
      check("d34_hold_d", 64'(avm_m0_writedata), 64'h0A0B);
    end
    idle(1'b0);
    check("d34_a1", 64'(avm_m0_address), 64'h100A);
    check("d34_d1", 64'(avm_m0_writedata), 64'h0C0D);
    idle(1'b0);

    // FIFO fill under constant stall; fifth request dropped
    for (int r = 0; r < 5; r++) begin
      step(1'b1, 1'b1, 1'b1, 32'h4000, 32'(r), 32'hA000_0000 + 32'(r * 32'h0101_0101));
      if (r == 3) check("d35_full", 64'(oready), 64'h0);
    end
    repeat (8) idle(1'b0);
    check("d35_drained", 64'(busy), 64'h0);

    // Back-to-back blocks without idle cycle
    step(1'b1, 1'b1, 1'b0, 32'h2000, 32'd0, 32'h11112222);
    step(1'b1, 1'b1, 1'b0, 32'h2000, 32'd1, 32'h33334444);
    check("d36_w", 64'(avm_m0_write), 64'h1);
    repeat (4) idle(1'b0);

    // Reset during second halfword
    step(1'b1, 1'b1, 1'b0, 32'h1000, 32'd2, 32'h0A0B0C0D);
    idle(1'b0);
    check("d37_a1", 64'(avm_m0_address), 64'h100A);
    step(1'b0, 1'b1, 1'b0, 32'h5000, 32'd7, 32'hDEADBEEF);
    check("d37_write", 64'(avm_m0_write), 64'h0);
    check("d37_busy", 64'(busy), 64'h0);
    check("d37_oready", 64'(oready), 64'h1);
    step(1'b1, 1'b1, 1'b0, 32'h3000, 32'd0, 32'h11223344);
    check("d37_new_a", 64'(avm_m0_address), 64'h3000);
    check("d37_new_d", 64'(avm_m0_writedata), 64'h1122);
    repeat (2) idle(1'b0);

    // Address wrap-around
    step(1'b1, 1'b1, 1'b0, 32'hFFFF_FFFC, 32'd1, 32'hCAFEF00D);
    check("d38_a0", 64'(avm_m0_address), 64'h0);
    idle(1'b0);
    check("d38_a1", 64'(avm_m0_address), 64'h2);
    idle(1'b0);

    // Random traffic with stalls and occasional resets
    for (int n = 0; n < 800; n++) begin
      step(1'($urandom_range(0, 60) != 0), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 3) == 0), $urandom(),
           ($urandom_range(0, 1) != 0) ? 32'($urandom_range(0, 15)) : $urandom(),
           BLOCKSZ'($urandom()));
    end
    repeat (2 * DEPTH * NHALF + 4) idle(1'b0);
    check("end_busy", 64'(busy), 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/writer.md
WRITER -- requirements
Module: writer

Interface
REQ-001 SHALL have parameter NDWORDS, default 1: number of 32-bit words per write block; block width BLOCKSZ = 32*NDWORDS.
REQ-002 SHALL have parameter FIFODEPTH, default 4: number of buffered write requests; power of two, at least 2.
REQ-003 SHALL have port clk, input, 1: the single clock; all logic updates on its rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-low reset.
REQ-005 SHALL have port baseaddr, input, 32: byte base address of the destination array; sampled with each accepted request.
REQ-006 SHALL have port index, input, 32: block index within the array; sampled with each accepted request.
REQ-007 SHALL have port write, input, 1: request strobe; one request per cycle in which write=1 and oready=1.
REQ-008 SHALL have port data, input, BLOCKSZ: block to store; sampled with each accepted request.
REQ-009 SHALL have port oready, output, 1: 1 when the request FIFO is not full.
REQ-010 SHALL have port busy, output, 1: 1 when the FIFO is non-empty or a bus transfer is in progress.
REQ-011 SHALL have port avm_m0_write, output, 1: Avalon-MM write request.
REQ-012 SHALL have port avm_m0_address, output, 32: Avalon-MM byte address.
REQ-013 SHALL have port avm_m0_writedata, output, 16: Avalon-MM write halfword.
REQ-014 SHALL have port avm_m0_byteenable, output, 2: driven to 2'b11 at all times.
REQ-015 SHALL have port avm_m0_waitrequest, input, 1: slave stall; while it is 1 the current transfer is not accepted.

Function
REQ-016 SHALL compute the block byte address as baseaddr + index*4*NDWORDS, using 32-bit arithmetic and discarding overflow (wrap-around modulo 2^32).
REQ-017 SHALL push {block address, data} into the FIFO on each accepted request; a request with write=1 and oready=0 SHALL be ignored and SHALL leave no state change.
REQ-018 SHALL split each block into 2*NDWORDS halfwords; halfword k goes to block address + 2k; k=0 carries data[BLOCKSZ-1:BLOCKSZ-16], with halfwords then proceeding in descending bit order.
REQ-019 SHALL use a state machine with two states: IDLE and XFER.
REQ-020 In IDLE with the FIFO non-empty, SHALL move to XFER on the next edge with k=0 and drive avm_m0_write=1.
REQ-021 In XFER, SHALL hold address, writedata and write=1 stable while waitrequest=1.
REQ-022 In XFER, when waitrequest=0, SHALL count the halfword as accepted and advance k.
REQ-023 On acceptance of the last halfword (k=2*NDWORDS-1), SHALL pop the FIFO entry.
REQ-024 After that pop, if the FIFO still holds an entry, SHALL remain in XFER and start the next block with k=0 on the following cycle, with no idle cycle; otherwise SHALL return to IDLE with write=0.
REQ-025 With waitrequest=0 throughout, a single request accepted at cycle t SHALL produce write=1 at cycles t+1 through t+2*NDWORDS.
REQ-026 SHALL derive oready from FIFO occupancy as registered at the start of the cycle; a pop in the same cycle SHALL NOT raise oready (no full-bypass). A simultaneous push and pop when not full SHALL keep occupancy unchanged.
REQ-027 SHALL drain FIFO entries in acceptance order.
REQ-028 SHALL keep avm_m0_write=0 in IDLE.
REQ-029 SHALL NOT let avm_m0_address or avm_m0_writedata change while write=1 and waitrequest=1.

Reset
REQ-030 While reset=0 at a rising edge, SHALL clear: state to IDLE, FIFO to empty, k to 0, avm_m0_write to 0, avm_m0_address to 0, avm_m0_writedata to 0, busy to 0, and oready to 1.
REQ-031 Reset asserted mid-transfer SHALL abandon the block in progress and all buffered entries, and SHALL deassert avm_m0_write at that edge; no partial block SHALL resume after reset.
REQ-032 Requests presented while reset=0 SHALL be ignored.

Verification
REQ-033 NDWORDS=1, waitrequest=0, baseaddr=0x1000, index=2, data=0x0A0B0C0D -> write 0x0A0B at 0x1008 (cycle t+1), then 0x0C0D at 0x100A (cycle t+2); busy falls at t+3.
REQ-034 Same request with waitrequest=1 for 3 cycles on the first halfword -> address 0x1008 and data 0x0A0B held for 4 cycles, then 0x0C0D at 0x100A.
REQ-035 waitrequest=1 constantly, 5 back-to-back requests with FIFODEPTH=4 -> oready=0 after the 4th; the 5th is dropped; releasing waitrequest drains exactly 8 halfwords in order.
REQ-036 Back-to-back requests for index 0 and 1 with waitrequest=0 -> 4 consecutive write=1 cycles at addresses base+0, +2, +4, +6.
REQ-037 reset=0 asserted on the second halfword of a block -> avm_m0_write=0 after that edge, busy=0, oready=1; a new request then starts at k=0.
REQ-038 baseaddr=0xFFFFFFFC, index=1 -> halfwords written at addresses 0x00000000 and 0x00000002 (wrap-around).
